// File: rtl/checker_mem_arbiter.sv
// checker_mem_arbiter: round-robin two-master Wishbone arbiter for the checker program memory,
// with the grant locked for the whole bus cycle and a per-access watchdog that ends a hung access with err.
module checker_mem_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);
   typedef enum logic [1:0] {IDLE, G0, G1} state_t;
   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             g0, g1, stb_raw, timeout;
   assign g0 = state_q == G0;
   assign g1 = state_q == G1;
   assign gnt_o = {g1, g0};
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   always_comb begin
      s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
      s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
      s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
      s_we_o   = g0 ? m0_we_i  : g1 ? m1_we_i  : 1'b0;
      s_cyc_o  = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
      stb_raw  = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
      // a same-cycle ack beats the watchdog
      timeout  = stb_raw && !s_ack_i && wd_q == CNT_W'(TIMEOUT);
      s_stb_o  = stb_raw && !timeout;
      m0_ack_o = s_ack_i && g0;
      m1_ack_o = s_ack_i && g1;
      m0_err_o = timeout && g0;
      m1_err_o = timeout && g1;
      state_d  = state_q == IDLE ? (m0_cyc_i && (!m1_cyc_i || last_q) ? G0 : m1_cyc_i ? G1 : IDLE)
               : state_q == G0   ? (m0_cyc_i ? G0 : m1_cyc_i ? G1 : IDLE)
               : state_q == G1   ? (m1_cyc_i ? G1 : m0_cyc_i ? G0 : IDLE)
               : IDLE;
      last_d   = g0 && state_d != G0 ? 1'b0 : g1 && state_d != G1 ? 1'b1 : last_q;
      wd_d     = state_d != state_q || s_ack_i || timeout ? '0
               : stb_raw ? wd_q + CNT_W'(1) : wd_q;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end
endmodule

// File: doc/checker_mem_arbiter.md
Name: checker_mem_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single Wishbone slave port of the checker program memory.
- Master 0 is the host/CSR-side loader; master 1 is the snapshot/DMA engine that patches checker code at run time.
- Round-robin grant, locked for the whole bus cycle (cyc held). A per-access watchdog terminates a hung slave access with an error.
- Sits between the system Wishbone interconnect and the checker memory's Wishbone slave port. The MPU read port is not touched.

Parameters:
- TIMEOUT, 255, cycles a granted stb may wait for s_ack_i before a one-cycle error is returned (1..65535).
- CNT_W, 16, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- sys_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  asynchronous active-low reset.
- m0_adr_i / m1_adr_i  in  32  master address.
- m0_dat_i / m1_dat_i  in  32  master write data.
- m0_sel_i / m1_sel_i  in  4  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_cyc_i / m1_cyc_i  in  1  cycle / bus request.
- m0_dat_o / m1_dat_o  out  32  read data (both driven from s_dat_i).
- m0_ack_o / m1_ack_o  out  1  acknowledge, routed to the granted master only.
- m0_err_o / m1_err_o  out  1  watchdog error, one-cycle pulse.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o  out  32,32,4,1,1,1  to memory slave.
- s_dat_i  in  32  memory read data.
- s_ack_i  in  1  memory acknowledge.
- gnt_o  out  2  one-hot current grant (debug/status).

Behaviour:
- Reset (async, sys_rst_n=0):
  - state=IDLE, gnt_o=2'b00, last=1 (so m0 wins the first tie), watchdog=0.
  - All m*_ack_o, m*_err_o, s_stb_o, s_cyc_o = 0.
  - Reset mid-access aborts immediately; no ack or err is produced for the aborted access.
- States: IDLE, G0, G1. Grant is registered; the slave bus is a combinational mux of the granted master. In IDLE the slave bus is all zero.
- IDLE:
  - m0_cyc only -> G0; m1_cyc only -> G1.
  - Both requesting -> grant the master != last.
- Gx, x granted:
  - Stay while mx_cyc_i=1.
  - On mx_cyc_i=0: if the other master's cyc=1 go directly to the other grant (no IDLE bubble), else IDLE. last<=x on leaving.
- Latency: cyc+stb asserted in IDLE at edge N -> grant at N+1 -> s_stb_o high in cycle N+1. The memory acks one cycle later, so the first ack reaches the master in cycle N+2.
- Ack routing:
  - mx_ack_o = s_ack_i & gnt[x].
  - Non-granted master sees ack=0 and err=0; its stb is ignored and held pending.
- Watchdog:
  - Counts cycles with s_stb_o=1 and s_ack_i=0; clears on s_ack_i, on grant change, and on error.
  - When count==TIMEOUT: mx_err_o=1 for one cycle, s_stb_o forced 0 in that cycle, counter cleared.
  - Grant is kept until the master drops cyc.
  - s_ack_i in the same cycle as timeout wins: ack delivered, no err.
- Back-to-back: a master may hold cyc across multiple stb/ack pairs (block transfer); the other master waits for the whole sequence.
- m*_dat_o = s_dat_i always; this is valid only with the corresponding ack.

Test Plan:
- Single m0 write adr=0x10, dat=0xA5A5A5A5, sel=4'hF -> gnt_o=01 one cycle after cyc, m0_ack_o at N+2, m1_ack_o stays 0; m0 read back returns 0xA5A5A5A5.
- m0 and m1 raise cyc in the same cycle after reset -> m0 granted first. m0 drops cyc -> gnt_o goes 01->10 on the next edge, with no IDLE cycle. The next simultaneous request grants m0 (last=1).
- m0 holds cyc for 4 consecutive reads while m1 requests -> m1 gets no ack until m0 drops cyc; then m1 is granted and acked.
- Slave ack tied low, TIMEOUT=8 -> m0_err_o pulses exactly once, 8 cycles after s_stb_o rises, and s_stb_o is 0 in that cycle. No ack is produced. The grant remains until m0 drops cyc.
- sys_rst_n pulsed low asynchronously mid-access (between clock edges) -> all outputs 0 immediately, gnt_o=00; after release a new m1 request is granted normally.
- s_ack_i arrives exactly in the timeout cycle -> ack is passed to the master, m*_err_o stays 0.
